// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// MDU stalls, branch flushes, and the registered hazard request line.
module hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              hazreset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwrite_m,
    input  logic              regwrite_w,
    input  logic              memread_e,
    input  logic              pcsrc_e,
    input  logic              mdu_start_e,
    output logic [1:0]        fwd_a_e,
    output logic [1:0]        fwd_b_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_e,
    output logic              flush_d,
    output logic              flush_e,
    output logic              flush_m,
    output logic              mdu_done,
    output logic              haz_req
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    mdu_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mdu_done_q, mdu_done_d;
    logic       haz_req_q, haz_req_d;
    logic       lwstall;
    logic       mdustall;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (regwrite_m && rd_m != '0 && rd_m == rs) begin
            sel = 2'b10;
        end else if (regwrite_w && rd_w != '0 && rd_w == rs) begin
            sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a_e = fwd_sel(rs1_e);
        fwd_b_e = fwd_sel(rs2_e);
    end

    always_comb begin
        lwstall = memread_e && (rd_e != '0)
                  && (rd_e == rs1_d || rd_e == rs2_d);
    end

    // A start seen while reset is held must not stall; the FSM is not running.
    always_comb begin
        mdustall = (state_q == BUSY)
                   || (state_q == IDLE && mdu_start_e && !hazreset);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (mdu_start_e) begin
                    state_d = BUSY;
                    cnt_d   = 4'(MDU_LAT - 1);
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        mdu_done_d = (state_d == DONE);
        haz_req_d  = lwstall | pcsrc_e | mdustall;
    end

    always_ff @(posedge clk or posedge hazreset) begin
        if (hazreset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            mdu_done_q <= 1'b0;
            haz_req_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mdu_done_q <= mdu_done_d;
            haz_req_q  <= haz_req_d;
        end
    end

    always_comb begin
        stall_f  = lwstall | mdustall;
        stall_d  = lwstall | mdustall;
        stall_e  = mdustall;
        flush_m  = mdustall;
        flush_d  = pcsrc_e & ~mdustall;
        flush_e  = (lwstall | pcsrc_e) & ~mdustall;
        mdu_done = mdu_done_q;
        haz_req  = haz_req_q;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver queues expected outputs per
// cycle, a monitor on the falling edge pops and compares them.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       hazreset = 1'b1;
    logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0;
    logic [4:0] rd_e = '0, rd_m = '0, rd_w = '0;
    logic       regwrite_m = 1'b0, regwrite_w = 1'b0;
    logic       memread_e = 1'b0, pcsrc_e = 1'b0, mdu_start_e = 1'b0;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       stall_f, stall_d, stall_e;
    logic       flush_d, flush_e, flush_m;
    logic       mdu_done, haz_req;

    // staged inputs, applied by cyc() just after a rising edge
    logic       s_rst = 1'b1;
    logic [4:0] s_rs1d = '0, s_rs2d = '0, s_rs1e = '0, s_rs2e = '0;
    logic [4:0] s_rde = '0, s_rdm = '0, s_rdw = '0;
    logic       s_rwm = 1'b0, s_rww = 1'b0, s_mr = 1'b0;
    logic       s_pc = 1'b0, s_ms = 1'b0;

    typedef struct {
        string      name;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] ctl;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    hazard_ctrl #(.MDU_LAT(4), .REG_AW(5)) dut (
        .clk(clk), .hazreset(hazreset),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
        .memread_e(memread_e), .pcsrc_e(pcsrc_e), .mdu_start_e(mdu_start_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .mdu_done(mdu_done), .haz_req(haz_req)
    );

    always #5 clk = ~clk;

    // ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_done, haz_req}
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] act;
            e   = exp_q.pop_front();
            act = {stall_f, stall_d, stall_e, flush_d,
                   flush_e, flush_m, mdu_done, haz_req};
            n_cmp++;
            if (fwd_a_e !== e.fa || fwd_b_e !== e.fb || act !== e.ctl) begin
                n_bad++;
                $display("FAIL %s: got fa=%b fb=%b ctl=%b, want fa=%b fb=%b ctl=%b",
                         e.name, fwd_a_e, fwd_b_e, act, e.fa, e.fb, e.ctl);
            end
        end
    end

    task automatic clr();
        s_rst = 1'b0;
        s_rs1d = '0; s_rs2d = '0; s_rs1e = '0; s_rs2e = '0;
        s_rde = '0; s_rdm = '0; s_rdw = '0;
        s_rwm = 1'b0; s_rww = 1'b0; s_mr = 1'b0;
        s_pc = 1'b0; s_ms = 1'b0;
    endtask

    task automatic cyc(input string nm, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [7:0] ctl);
        exp_t e;
        @(posedge clk);
        #1;
        hazreset = s_rst;
        rs1_d = s_rs1d; rs2_d = s_rs2d; rs1_e = s_rs1e; rs2_e = s_rs2e;
        rd_e = s_rde; rd_m = s_rdm; rd_w = s_rdw;
        regwrite_m = s_rwm; regwrite_w = s_rww; memread_e = s_mr;
        pcsrc_e = s_pc; mdu_start_e = s_ms;
        e.name = nm; e.fa = fa; e.fb = fb; e.ctl = ctl;
        exp_q.push_back(e);
    endtask

    initial begin
        cyc("reset", 2'b00, 2'b00, 8'b0000_0000);
        clr();
        cyc("idle", 2'b00, 2'b00, 8'b0000_0000);

        s_rs1e = 5; s_rdm = 5; s_rwm = 1; s_rdw = 5; s_rww = 1;
        cyc("fwd_mem_wins", 2'b10, 2'b00, 8'b0000_0000);
        s_rwm = 0;
        cyc("fwd_wb", 2'b01, 2'b00, 8'b0000_0000);
        s_rwm = 1; s_rdm = 0; s_rdw = 0;
        cyc("fwd_x0", 2'b00, 2'b00, 8'b0000_0000);
        s_rs1e = 3; s_rs2e = 9; s_rdm = 3; s_rdw = 9;
        cyc("fwd_a_mem_b_wb", 2'b10, 2'b01, 8'b0000_0000);
        s_rs1e = 4; s_rdm = 9;
        cyc("fwd_b_mem", 2'b00, 2'b10, 8'b0000_0000);

        clr(); s_mr = 1; s_rde = 7; s_rs2d = 7;
        cyc("lduse_rs2", 2'b00, 2'b00, 8'b1100_1000);
        clr(); s_mr = 1;
        cyc("lduse_x0", 2'b00, 2'b00, 8'b0000_0001);
        s_rde = 7; s_rs1d = 7;
        cyc("lduse_rs1", 2'b00, 2'b00, 8'b1100_1000);
        clr();
        cyc("lduse_hreq", 2'b00, 2'b00, 8'b0000_0001);

        s_pc = 1;
        cyc("branch", 2'b00, 2'b00, 8'b0001_1000);
        clr();
        cyc("branch_hreq", 2'b00, 2'b00, 8'b0000_0001);
        cyc("branch_quiet", 2'b00, 2'b00, 8'b0000_0000);
        s_pc = 1; s_mr = 1; s_rde = 2; s_rs1d = 2;
        cyc("branch_lduse", 2'b00, 2'b00, 8'b1101_1000);
        clr();
        cyc("branch_lduse_hreq", 2'b00, 2'b00, 8'b0000_0001);

        s_ms = 1;
        cyc("mdu_t0", 2'b00, 2'b00, 8'b1110_0100);
        cyc("mdu_t1", 2'b00, 2'b00, 8'b1110_0101);
        s_pc = 1;
        cyc("mdu_t2_branch", 2'b00, 2'b00, 8'b1110_0101);
        s_pc = 0;
        cyc("mdu_t3", 2'b00, 2'b00, 8'b1110_0101);
        cyc("mdu_t4_done", 2'b00, 2'b00, 8'b0000_0011);
        s_ms = 0;
        cyc("mdu_t5_idle", 2'b00, 2'b00, 8'b0000_0000);

        s_ms = 1;
        cyc("mdu_r_t0", 2'b00, 2'b00, 8'b1110_0100);
        cyc("mdu_r_t1", 2'b00, 2'b00, 8'b1110_0101);
        s_rst = 1;
        cyc("mdu_r_reset", 2'b00, 2'b00, 8'b0000_0000);
        s_rst = 0;
        cyc("mdu_r2_t0", 2'b00, 2'b00, 8'b1110_0100);
        cyc("mdu_r2_t1", 2'b00, 2'b00, 8'b1110_0101);
        cyc("mdu_r2_t2", 2'b00, 2'b00, 8'b1110_0101);
        cyc("mdu_r2_t3", 2'b00, 2'b00, 8'b1110_0101);
        cyc("mdu_r2_done", 2'b00, 2'b00, 8'b0000_0011);
        s_ms = 0;
        cyc("mdu_r2_idle", 2'b00, 2'b00, 8'b0000_0000);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core.
- Produces forwarding selects, load-use stalls and branch flushes.
- Sequences multi-cycle multiply/divide stalls through a small FSM plus counter.
- Drives the registered hazard-request line haz_req, which feeds the input of the downstream hazard-extension FSM.

Parameters:
- MDU_LAT, 4, total stall cycles for a multi-cycle MDU op in EX; legal range 2..15.
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  clock
- hazreset  in  1  asynchronous reset, active-high
- rs1_d  in  REG_AW  source reg 1 of the instruction in ID
- rs2_d  in  REG_AW  source reg 2 of the instruction in ID
- rs1_e  in  REG_AW  source reg 1 of the instruction in EX
- rs2_e  in  REG_AW  source reg 2 of the instruction in EX
- rd_e  in  REG_AW  dest reg of EX
- rd_m  in  REG_AW  dest reg of MEM
- rd_w  in  REG_AW  dest reg of WB
- regwrite_m  in  1  MEM writes rd_m
- regwrite_w  in  1  WB writes rd_w
- memread_e  in  1  EX holds a load
- pcsrc_e  in  1  branch/jump taken, resolved in EX
- mdu_start_e  in  1  EX holds a multi-cycle MDU op; stays high while the op is held in EX
- fwd_a_e  out  2  ALU operand A select: 00 regfile, 01 WB, 10 MEM
- fwd_b_e  out  2  ALU operand B select, same encoding
- stall_f  out  1  hold PC
- stall_d  out  1  hold IF/ID
- stall_e  out  1  hold ID/EX
- flush_d  out  1  bubble IF/ID
- flush_e  out  1  bubble ID/EX
- flush_m  out  1  bubble EX/MEM
- mdu_done  out  1  one-cycle pulse: MDU result valid, EX may advance
- haz_req  out  1  registered OR of all hazard events, to the hazard-extension FSM

Behaviour:
- Forwarding (combinational), A shown; B identical using rs2_e:
  - fwd_a_e = 10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
  - else 01 if regwrite_w && rd_w!=0 && rd_w==rs1_e.
  - else 00.
  - MEM beats WB when both match.
- Load-use: lwstall = memread_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d). Register x0 never hazards.
- MDU FSM states IDLE, BUSY, DONE; 4-bit counter cnt.
  - IDLE: mdu_start_e=1 -> BUSY, cnt<=MDU_LAT-1; mdustall=1 this cycle. Else stay.
  - BUSY: mdustall=1, cnt<=cnt-1. When cnt==1 -> DONE.
  - DONE: mdustall=0, mdu_done=1. The still-high mdu_start_e is ignored. -> IDLE unconditionally.
  - Net effect: exactly MDU_LAT stall cycles from the start cycle, then one DONE cycle in which EX advances.
  - mdu_start_e is ignored in BUSY and DONE.
- Control outputs (combinational):
  - stall_f = stall_d = lwstall | mdustall.
  - stall_e = mdustall.
  - flush_m = mdustall.
  - flush_d = pcsrc_e & ~mdustall.
  - flush_e = (lwstall | pcsrc_e) & ~mdustall. Hold beats bubble.
  - Simultaneous pcsrc_e and lwstall: flush_e=1 and flush_d=1; stall_f/stall_d also 1. The PC mux gives branch priority, outside this block.
  - mdu_start_e && pcsrc_e together is illegal upstream. If it occurs, the MDU path wins per the equations above.
- haz_req: on each posedge clk, haz_req <= lwstall | pcsrc_e | mdustall. One-cycle latency.
- Reset (async, immediate, including mid-operation): state=IDLE, cnt=0, haz_req=0, mdu_done=0. With all inputs 0, every output is 0. After deassertion, the first posedge evaluates normally.

Test Plan:
- Forwarding: rs1_e=5, rd_m=5, regwrite_m=1, rd_w=5, regwrite_w=1 -> fwd_a_e=10. Drop regwrite_m -> 01. Set rd_m=rd_w=0 -> 00.
- Load-use: memread_e=1, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 same cycle; haz_req=1 next cycle. Repeat with rd_e=0 -> all 0.
- MDU, MDU_LAT=4: mdu_start_e held high from T0 -> stall_d=stall_e=flush_m=1 during T0-T3; T4 mdu_done=1, stall_e=0; T5 IDLE.
- Branch: pcsrc_e=1 for one cycle -> flush_d=flush_e=1 that cycle; haz_req=1 next cycle, then 0.
- Branch during MDU BUSY: pcsrc_e=1 at T2 -> flush_d=flush_e=0, stall_e=1.
- Reset mid-BUSY: hazreset at T2 -> stall_e, haz_req and mdu_done drop to 0 immediately. After release with mdu_start_e=1, a fresh 4-cycle stall begins.
